// File: rtl/irq_seq.sv
// Interrupt entry/return sequencer: picks the highest-priority pending source at an
// instruction boundary, saves PC/flags, and restores them on RETI. Optional IRQ_SEQ_AUTO_ACK_EN.
module irq_seq #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter int unsigned VECTOR_STRIDE = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  irq_status_i,
  input  logic [2:0]  irq_enable_i,
  input  logic        instr_done_i,
  input  logic [15:0] cur_pc_i,
  input  logic [2:0]  cur_flags_i,
  input  logic        gie_set_i,
  input  logic        gie_clr_i,
  input  logic        reti_i,
  input  logic        vec_ack_i,
  output logic        take_irq_o,
  output logic [15:0] irq_vector_o,
  output logic [15:0] epc_o,
  output logic [2:0]  eflags_o,
  output logic        restore_o,
  output logic        gie_o,
  output logic        in_isr_o,
  output logic [15:0] ack_data_o,
  output logic        ack_write_o
);

  typedef enum logic [1:0] {StIdle, StReq, StIsr, StRet} state_e;

  state_e      state_q, state_d;
  logic        gie_q, gie_d;
  logic [15:0] epc_q, epc_d;
  logic [2:0]  eflags_q, eflags_d;
  logic [15:0] vec_q, vec_d;
  logic [2:0]  pend;
  logic [1:0]  id;
  logic [15:0] vec_calc;

`ifdef IRQ_SEQ_AUTO_ACK_EN
  logic [1:0] id_q, id_d;
  logic       ack_q, ack_d;
`endif

  // Bit 0 has the highest priority.
  always_comb begin
    pend = irq_status_i & irq_enable_i;
    if (pend[0])      id = 2'd0;
    else if (pend[1]) id = 2'd1;
    else              id = 2'd2;
    vec_calc = VECTOR_BASE + 16'(VECTOR_STRIDE) * {14'd0, id};
  end

  always_comb begin
    state_d  = state_q;
    gie_d    = gie_q;
    epc_d    = epc_q;
    eflags_d = eflags_q;
    vec_d    = vec_q;
`ifdef IRQ_SEQ_AUTO_ACK_EN
    id_d     = id_q;
    ack_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (gie_clr_i)      gie_d = 1'b0;
        else if (gie_set_i) gie_d = 1'b1;
        if (instr_done_i && gie_q && !gie_clr_i && (|pend)) begin
          state_d  = StReq;
          vec_d    = vec_calc;
          epc_d    = cur_pc_i;
          eflags_d = cur_flags_i;
          gie_d    = 1'b0;
`ifdef IRQ_SEQ_AUTO_ACK_EN
          id_d     = id;
`endif
        end
      end
      StReq: begin
        if (vec_ack_i) begin
          state_d = StIsr;
`ifdef IRQ_SEQ_AUTO_ACK_EN
          ack_d   = 1'b1;
`endif
        end
      end
      StIsr: begin
        if (reti_i) state_d = StRet;
      end
      StRet: begin
        gie_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      gie_q    <= 1'b0;
      epc_q    <= 16'h0;
      eflags_q <= 3'b0;
      vec_q    <= 16'h0;
`ifdef IRQ_SEQ_AUTO_ACK_EN
      id_q     <= 2'd0;
      ack_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gie_q    <= gie_d;
      epc_q    <= epc_d;
      eflags_q <= eflags_d;
      vec_q    <= vec_d;
`ifdef IRQ_SEQ_AUTO_ACK_EN
      id_q     <= id_d;
      ack_q    <= ack_d;
`endif
    end
  end

  // Strobes are masked by reset so they drop in the reset cycle itself.
  assign take_irq_o   = (state_q == StReq) && !reset_i;
  assign restore_o    = (state_q == StRet) && !reset_i;
  assign in_isr_o     = (state_q == StIsr) || (state_q == StRet);
  assign gie_o        = gie_q;
  assign irq_vector_o = vec_q;
  assign epc_o        = epc_q;
  assign eflags_o     = eflags_q;

`ifdef IRQ_SEQ_AUTO_ACK_EN
  assign ack_write_o = ack_q && !reset_i;
  assign ack_data_o  = ack_q ? (16'h1 << id_q) : 16'h0;
`else
  assign ack_write_o = 1'b0;
  assign ack_data_o  = 16'h0;
`endif

endmodule
